// File: rtl/team_06_pkg.sv
// team_06_pkg: shared types for the tick timer block.
package team_06_pkg;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;
endpackage

// File: rtl/team_06_tick_timer.sv
// team_06_tick_timer: counts divided-clock rising edges down from a loaded value, with hold, cancel and retrigger.
module team_06_tick_timer
   import team_06_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             div_clk,
   input  logic             div_clk_past,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             hold,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             expired,
   output logic [WIDTH-1:0] remaining
);
   timer_state_t state;
   logic tick;
   assign tick = div_clk & ~div_clk_past;
   assign busy = (state == RUN) || (state == PAUSE);
   assign expired = state == DONE;
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
         remaining <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (cancel) begin
            state <= IDLE;
            remaining <= '0;
         end else if (start) begin
            remaining <= load_val;
            state <= (load_val != '0) ? RUN : DONE;
            done <= load_val == '0;
         end else if (state == RUN) begin
            if (hold)
               state <= PAUSE;
            else if (tick && remaining != '0) begin
               remaining <= remaining - WIDTH'(1);
               if (remaining == WIDTH'(1)) begin
                  state <= DONE;
                  done <= 1'b1;
               end
            end
         end else if (state == PAUSE && !hold)
            state <= RUN;
      end
   end
endmodule
